// File: rtl/snpu_pkg.sv
// snpu_pkg: shared types and helpers for the SNPU LIF neuron array.
// Holds the sweep FSM state enum, a width-parametrised saturating signed add,
// and the index/address width helpers used to size counters and buses.
package snpu_pkg;

  // Sweep FSM states, also driven out on the debug state port.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAK  = 3'd1,
    S_ACCUM = 3'd2,
    S_FIRE  = 3'd3,
    S_DONE  = 3'd4
  } snpu_state_e;

  // Widest operand the saturating adder handles.
  localparam int unsigned SAT_MAX_W = 32;

  // Width of an index able to address n items (at least one bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Signed add of two sign-extended operands, clamped to a w-bit signed range.
  function automatic logic signed [SAT_MAX_W-1:0] sat_add(
    input logic signed [SAT_MAX_W-1:0] a,
    input logic signed [SAT_MAX_W-1:0] b,
    input int unsigned                 w
  );
    logic signed [SAT_MAX_W:0] sum;
    logic signed [SAT_MAX_W:0] hi;
    logic signed [SAT_MAX_W:0] lo;
    sum = (SAT_MAX_W+1)'(a) + (SAT_MAX_W+1)'(b);
    hi  = ((33'sd1 <<< (w - 1)) - 33'sd1);
    lo  = -(33'sd1 <<< (w - 1));
    if (sum > hi) begin
      return hi[SAT_MAX_W-1:0];
    end else if (sum < lo) begin
      return lo[SAT_MAX_W-1:0];
    end else begin
      return sum[SAT_MAX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/snpu_lif_array_weight_mem.sv
// snpu_weight_mem: N_NEU*N_IN x W_W synaptic weight register file.
// One write port, one combinational read port, asynchronous reset to zero.
module snpu_weight_mem
  import snpu_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W_W   = 4,
  parameter int unsigned AW    = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [W_W-1:0] wr_data,
  input  logic [AW-1:0]  rd_addr,
  output logic [W_W-1:0] rd_data
);

  logic [W_W-1:0] mem_q [DEPTH];
  logic [W_W-1:0] mem_d [DEPTH];

  // Next-state of the array: a single word replaced on a write strobe.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Weight storage, cleared to zero on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/snpu_lif_array.sv
// snpu_lif_array: time-multiplexed leaky integrate-and-fire neuron array.
// Each accepted tick sweeps every neuron through one shared datapath:
// LEAK (1 cycle), ACCUM (one input per cycle), FIRE (1 cycle), then one DONE
// cycle publishes the spike vector. Optional build macro SNPU_REFRACTORY_EN
// adds a per-neuron refractory counter; without it no counters exist.
// Handshake: tick is a strobe honoured only while idle (busy low); done is a
// one-cycle pulse coinciding with the spike_out update; busy drops the cycle
// after done and a new tick is accepted from that cycle on.
module snpu_lif_array
  import snpu_pkg::*;
#(
  parameter int N_IN         = 4,
  parameter int N_NEU        = 4,
  parameter int POT_W        = 8,
  parameter int W_W          = 4,
  parameter int LEAK_SHIFT   = 3,
  parameter int REFRAC_TICKS = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tick,
  input  logic [N_IN-1:0]                 spike_in,
  input  logic [POT_W-1:0]                threshold,
  output logic                            busy,
  output logic                            done,
  output logic [N_NEU-1:0]                spike_out,
  input  logic                            wr_en,
  input  logic [$clog2(N_NEU*N_IN)-1:0]   wr_addr,
  input  logic [W_W-1:0]                  wr_data,
  input  logic [$clog2(N_NEU)-1:0]        pot_sel,
  output logic [POT_W-1:0]                pot_out,
  output snpu_state_e                     state_dbg
);

  localparam int unsigned DEPTH = N_NEU * N_IN;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned NW    = idx_w(N_NEU);
  localparam int unsigned IW    = idx_w(N_IN);

  snpu_state_e state_q, state_d;
  logic [NW-1:0]           n_q, n_d;
  logic [IW-1:0]           i_q, i_d;
  logic signed [POT_W-1:0] acc_q, acc_d;
  logic signed [POT_W-1:0] thr_q, thr_d;
  logic [N_IN-1:0]         spk_lat_q, spk_lat_d;
  logic [N_NEU-1:0]        next_spike_q, next_spike_d;
  logic signed [POT_W-1:0] pot_q [N_NEU];
  logic signed [POT_W-1:0] pot_d [N_NEU];
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [N_NEU-1:0]        spike_out_q, spike_out_d;
  logic [POT_W-1:0]        pot_out_q, pot_out_d;

  logic                    in_refrac;
  logic                    mem_we;
  logic [AW-1:0]           rd_addr;
  logic [W_W-1:0]          w_rd;
  logic signed [31:0]      pot_ext;
  logic signed [31:0]      acc_ext;
  logic signed [31:0]      w_ext;

`ifdef SNPU_REFRACTORY_EN
  localparam int unsigned RW = idx_w(REFRAC_TICKS + 1);
  logic [RW-1:0] ref_q [N_NEU];
  logic [RW-1:0] ref_d [N_NEU];
  assign in_refrac = (ref_q[n_q] != '0);
`else
  assign in_refrac = 1'b0;
`endif

  // Weights are only writable between sweeps; writes while busy are dropped.
  assign mem_we  = wr_en && (state_q == S_IDLE);
  assign rd_addr = AW'(int'(n_q) * N_IN + int'(i_q));

  snpu_weight_mem #(
    .DEPTH (DEPTH),
    .W_W   (W_W),
    .AW    (AW)
  ) u_weight_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (mem_we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (w_rd)
  );

  assign pot_ext = 32'(pot_q[n_q]);
  assign acc_ext = 32'(acc_q);
  assign w_ext   = 32'($signed(w_rd));

  // Sweep sequencing and the shared leak/accumulate/fire datapath.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    i_d          = i_q;
    acc_d        = acc_q;
    thr_d        = thr_q;
    spk_lat_d    = spk_lat_q;
    next_spike_d = next_spike_q;
    pot_d        = pot_q;
`ifdef SNPU_REFRACTORY_EN
    ref_d        = ref_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          spk_lat_d    = spike_in;
          thr_d        = threshold;
          n_d          = '0;
          next_spike_d = '0;
          state_d      = S_LEAK;
        end
      end
      S_LEAK: begin
        // A refractory neuron integrates nothing and stays at zero.
        if (in_refrac) begin
          acc_d = '0;
        end else begin
          acc_d = POT_W'(sat_add(pot_ext, -(pot_ext >>> LEAK_SHIFT), POT_W));
        end
        i_d     = '0;
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (spk_lat_q[i_q] && !in_refrac) begin
          acc_d = POT_W'(sat_add(acc_ext, w_ext, POT_W));
        end
        if (i_q == IW'(N_IN - 1)) begin
          state_d = S_FIRE;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      S_FIRE: begin
        if (in_refrac) begin
          pot_d[n_q] = '0;
`ifdef SNPU_REFRACTORY_EN
          ref_d[n_q] = ref_q[n_q] - 1'b1;
`endif
        end else if (acc_q >= thr_q) begin
          next_spike_d[n_q] = 1'b1;
          pot_d[n_q]        = '0;
`ifdef SNPU_REFRACTORY_EN
          ref_d[n_q]        = RW'(REFRAC_TICKS);
`endif
        end else begin
          pot_d[n_q] = acc_q;
        end
        if (n_q == NW'(N_NEU - 1)) begin
          state_d = S_DONE;
        end else begin
          n_d     = n_q + 1'b1;
          state_d = S_LEAK;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs derived from the upcoming state so they align with it.
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    spike_out_d = (state_d == S_DONE) ? next_spike_d : spike_out_q;
    pot_out_d   = pot_q[pot_sel];
  end

  // All sweep state, potentials and outputs; reset aborts any sweep at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      i_q          <= '0;
      acc_q        <= '0;
      thr_q        <= '0;
      spk_lat_q    <= '0;
      next_spike_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      spike_out_q  <= '0;
      pot_out_q    <= '0;
      for (int k = 0; k < N_NEU; k++) begin
        pot_q[k] <= '0;
`ifdef SNPU_REFRACTORY_EN
        ref_q[k] <= '0;
`endif
      end
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      i_q          <= i_d;
      acc_q        <= acc_d;
      thr_q        <= thr_d;
      spk_lat_q    <= spk_lat_d;
      next_spike_q <= next_spike_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      spike_out_q  <= spike_out_d;
      pot_out_q    <= pot_out_d;
      pot_q        <= pot_d;
`ifdef SNPU_REFRACTORY_EN
      ref_q        <= ref_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign spike_out = spike_out_q;
  assign pot_out   = pot_out_q;
  assign state_dbg = state_q;

endmodule
